// File: rtl/rv32i_types.sv
// Shared types and defaults for the out-of-order back end.
//
// Contents:
//   RS_NUM_ENTRIES / RS_NUM_FU / RS_NUM_CDB : reservation station sizing defaults
//   RS_PS_W / RS_ROB_W / RS_OP_W / RS_RD_W   : tag and payload field widths
//   rs_entry_t                               : payload carried by an RS entry and
//                                              presented on each issue channel
//
// rs_entry_t is built from the package widths, so any reservation station
// that carries it must be configured with matching PS_W/ROB_W/OP_W.
package rv32i_types;

  localparam int RS_NUM_ENTRIES = 8;
  localparam int RS_NUM_FU      = 2;
  localparam int RS_NUM_CDB     = 2;

  localparam int RS_PS_W  = 6;
  localparam int RS_ROB_W = 5;
  localparam int RS_OP_W  = 8;
  localparam int RS_RD_W  = 5;

  typedef struct packed {
    logic [RS_PS_W-1:0]  ps1;
    logic [RS_PS_W-1:0]  ps2;
    logic [RS_PS_W-1:0]  pd;
    logic [RS_RD_W-1:0]  rd;
    logic [RS_ROB_W-1:0] rob_entry;
    logic [RS_OP_W-1:0]  op;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_select.sv
// Per-channel issue selector for the reservation station.
//
// Ports:
//   req   [NUM_ENTRIES]              : entries eligible for this channel
//   age   [NUM_ENTRIES][NUM_ENTRIES] : only with RS_AGE_PRIO_EN; age[i][j] set
//                                      means entry i is older than entry j
//   grant [NUM_ENTRIES]              : one-hot winner (zero when req is zero)
//   any                              : at least one request present
//
// Build option RS_AGE_PRIO_EN: oldest requester wins. Otherwise the
// lowest-index requester wins and the age input does not exist.
module rs_issue_select #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0]                  req,
`ifdef RS_AGE_PRIO_EN
  input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age,
`endif
  output logic [NUM_ENTRIES-1:0]                  grant,
  output logic                                    any
);

  assign any = |req;

`ifdef RS_AGE_PRIO_EN
  // An entry wins when no other requester is older than it. The age
  // relation is a total order over busy entries, so exactly one wins.
  genvar gi;
  for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_grant
    logic blocked;
    always_comb begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != gi && req[j] && age[j][gi]) blocked = 1'b1;
      end
    end
    assign grant[gi] = req[gi] & ~blocked;
  end
`else
  // Isolate the lowest set bit.
  assign grant = req & (~req + NUM_ENTRIES'(1));
`endif

endmodule

// File: rtl/reservation_station_param.sv
// Unified reservation station with per-FU issue channels and CDB wakeup.
//
// Ports:
//   clk, rst (async, active low), flush        : clock, reset, squash-all
//   dispatch_*                                 : one dispatch per cycle into the
//                                                lowest free entry; dispatch_ready
//                                                is high while any entry is free
//   cdb_valid/cdb_pd [NUM_CDB]                 : tag broadcasts that wake sources
//   fu_ready [NUM_FU]                          : channel may issue this cycle
//   issue_valid/issue_entry [NUM_FU]           : per-channel issue; payload is zero
//                                                when the channel does not issue
//   occupancy                                  : number of busy entries
//
// Build option RS_AGE_PRIO_EN: each channel issues its oldest ready entry,
// tracked by an NUM_ENTRIES x NUM_ENTRIES age matrix. Without it the
// lowest-index ready entry issues and no age state is kept.
module reservation_station_param
  import rv32i_types::*;
#(
  parameter  int NUM_ENTRIES = RS_NUM_ENTRIES,
  parameter  int NUM_FU      = RS_NUM_FU,
  parameter  int NUM_CDB     = RS_NUM_CDB,
  parameter  int PS_W        = RS_PS_W,
  parameter  int ROB_W       = RS_ROB_W,
  parameter  int OP_W        = RS_OP_W,
  localparam int FU_W        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int IDX_W       = $clog2(NUM_ENTRIES),
  localparam int OCC_W       = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [FU_W-1:0]               dispatch_fu_sel,
  input  logic [PS_W-1:0]               dispatch_ps1,
  input  logic [PS_W-1:0]               dispatch_ps2,
  input  logic                          dispatch_ps1_ready,
  input  logic                          dispatch_ps2_ready,
  input  logic [PS_W-1:0]               dispatch_pd,
  input  logic [4:0]                    dispatch_rd,
  input  logic [ROB_W-1:0]              dispatch_rob_entry,
  input  logic [OP_W-1:0]               dispatch_op,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB-1:0][PS_W-1:0]  cdb_pd,
  input  logic [NUM_FU-1:0]             fu_ready,
  output logic [NUM_FU-1:0]             issue_valid,
  output rs_entry_t [NUM_FU-1:0]        issue_entry,
  output logic [OCC_W-1:0]              occupancy
);

  logic [NUM_ENTRIES-1:0] busy_reg, busy_next;
  logic [NUM_ENTRIES-1:0] ps1_v_reg, ps1_v_next;
  logic [NUM_ENTRIES-1:0] ps2_v_reg, ps2_v_next;
  logic [FU_W-1:0]        fu_reg [NUM_ENTRIES];
  rs_entry_t              payload_reg [NUM_ENTRIES];
  logic [OCC_W-1:0]       occ_reg, occ_next;

  logic [NUM_ENTRIES-1:0]             wake1, wake2, ready_vec, issue_clr;
  logic [NUM_FU-1:0][NUM_ENTRIES-1:0] ch_clr;
  logic [OCC_W-1:0]                   issue_cnt;
  logic                               free_found, accept;
  logic [IDX_W-1:0]                   free_idx;
  logic                               disp_ps1_rdy, disp_ps2_rdy;
  rs_entry_t                          disp_entry;

`ifdef RS_AGE_PRIO_EN
  // age_reg[i][j] set: entry i was dispatched before entry j.
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_reg;
`endif

  // Lowest free entry; scanning downward lets the lowest index win.
  // Entries issuing this cycle are still busy here, so they never count.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = free_found;
  assign accept         = dispatch_valid & free_found & ~flush;
  assign occupancy      = occ_reg;
  assign ready_vec      = busy_reg & ps1_v_reg & ps2_v_reg;

  // Source readiness at dispatch: RAT state, the hardwired-ready tag 0,
  // or a same-cycle CDB broadcast of the tag.
  always_comb begin
    disp_ps1_rdy = dispatch_ps1_ready || (dispatch_ps1 == '0);
    disp_ps2_rdy = dispatch_ps2_ready || (dispatch_ps2 == '0);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_pd[k] == dispatch_ps1) disp_ps1_rdy = 1'b1;
      if (cdb_valid[k] && cdb_pd[k] == dispatch_ps2) disp_ps2_rdy = 1'b1;
    end
  end

  always_comb begin
    disp_entry           = '0;
    disp_entry.ps1       = dispatch_ps1;
    disp_entry.ps2       = dispatch_ps2;
    disp_entry.pd        = dispatch_pd;
    disp_entry.rd        = dispatch_rd;
    disp_entry.rob_entry = dispatch_rob_entry;
    disp_entry.op        = dispatch_op;
  end

  // CDB tag match against every stored source.
  genvar gi;
  for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_wake
    logic w1, w2;
    always_comb begin
      w1 = 1'b0;
      w2 = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid[k] && cdb_pd[k] == payload_reg[gi].ps1) w1 = 1'b1;
        if (cdb_valid[k] && cdb_pd[k] == payload_reg[gi].ps2) w2 = 1'b1;
      end
    end
    assign wake1[gi] = w1;
    assign wake2[gi] = w2;
  end

  // One selector per channel. Each entry targets exactly one channel,
  // so grants from different channels never overlap.
  for (gi = 0; gi < NUM_FU; gi++) begin : g_ch
    logic [NUM_ENTRIES-1:0] req, grant;
    logic                   any;
    rs_entry_t              sel_entry;

    always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        req[i] = ready_vec[i] && (fu_reg[i] == FU_W'(gi));
      end
    end

    rs_issue_select #(
      .NUM_ENTRIES(NUM_ENTRIES)
    ) u_sel (
      .req   (req),
`ifdef RS_AGE_PRIO_EN
      .age   (age_reg),
`endif
      .grant (grant),
      .any   (any)
    );

    assign issue_valid[gi] = any & fu_ready[gi] & ~flush;
    assign ch_clr[gi]      = issue_valid[gi] ? grant : '0;

    always_comb begin
      sel_entry = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (grant[i]) sel_entry = sel_entry | payload_reg[i];
      end
      if (!issue_valid[gi]) sel_entry = '0;
    end
    assign issue_entry[gi] = sel_entry;
  end

  always_comb begin
    issue_clr = '0;
    issue_cnt = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      issue_clr = issue_clr | ch_clr[f];
      issue_cnt = issue_cnt + OCC_W'(issue_valid[f]);
    end
  end

  always_comb begin
    busy_next  = busy_reg & ~issue_clr;
    ps1_v_next = ps1_v_reg | wake1;
    ps2_v_next = ps2_v_reg | wake2;
    if (accept) begin
      busy_next[free_idx]  = 1'b1;
      ps1_v_next[free_idx] = disp_ps1_rdy;
      ps2_v_next[free_idx] = disp_ps2_rdy;
    end
    occ_next = occ_reg + OCC_W'(accept) - issue_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg  <= '0;
      ps1_v_reg <= '0;
      ps2_v_reg <= '0;
      occ_reg   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        fu_reg[i]      <= '0;
        payload_reg[i] <= '0;
      end
    end else if (flush) begin
      busy_reg  <= '0;
      ps1_v_reg <= '0;
      ps2_v_reg <= '0;
      occ_reg   <= '0;
    end else begin
      busy_reg  <= busy_next;
      ps1_v_reg <= ps1_v_next;
      ps2_v_reg <= ps2_v_next;
      occ_reg   <= occ_next;
      if (accept) begin
        fu_reg[free_idx]      <= dispatch_fu_sel;
        payload_reg[free_idx] <= disp_entry;
      end
    end
  end

`ifdef RS_AGE_PRIO_EN
  // A new dispatch becomes younger than every other entry. Rows of
  // freed entries go stale but are rewritten when the slot is reused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_reg <= '0;
    end else if (accept) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        age_reg[free_idx][j] <= 1'b0;
        age_reg[j][free_idx] <= (j != int'(free_idx));
      end
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station_param.sv
// Self-checking bench for reservation_station_param (default parameters).
// Works with or without RS_AGE_PRIO_EN; the reference model picks the
// oldest entry by dispatch sequence number when the macro is defined.
module tb_reservation_station_param;
  import rv32i_types::*;

  localparam int N  = 8;
  localparam int NF = 2;
  localparam int NC = 2;
  localparam int PW = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  logic                   dispatch_valid = 1'b0;
  logic                   dispatch_ready;
  logic [0:0]             dispatch_fu_sel = '0;
  logic [PW-1:0]          dispatch_ps1 = '0, dispatch_ps2 = '0, dispatch_pd = '0;
  logic                   dispatch_ps1_ready = 1'b0, dispatch_ps2_ready = 1'b0;
  logic [4:0]             dispatch_rd = '0;
  logic [4:0]             dispatch_rob_entry = '0;
  logic [7:0]             dispatch_op = '0;
  logic [NC-1:0]          cdb_valid = '0;
  logic [NC-1:0][PW-1:0]  cdb_pd = '0;
  logic [NF-1:0]          fu_ready = '1;
  logic [NF-1:0]          issue_valid;
  rs_entry_t [NF-1:0]     issue_entry;
  logic [3:0]             occupancy;

  reservation_station_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_fu_sel(dispatch_fu_sel),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps1_ready(dispatch_ps1_ready), .dispatch_ps2_ready(dispatch_ps2_ready),
    .dispatch_pd(dispatch_pd), .dispatch_rd(dispatch_rd),
    .dispatch_rob_entry(dispatch_rob_entry), .dispatch_op(dispatch_op),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_entry(issue_entry), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_busy[N];
  bit        m_r1[N], m_r2[N];
  int        m_fu[N];
  rs_entry_t m_ent[N];
  longint    m_seq[N];
  longint    seq_ctr;
  int        m_pick[NF];
  bit        exp_ready;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_fu[i] = 0; m_ent[i] = '0; m_seq[i] = 0;
    end
    seq_ctr = 0;
  endfunction

  function automatic bit cdb_hit(input logic [PW-1:0] tag);
    for (int k = 0; k < NC; k++) if (cdb_valid[k] && cdb_pd[k] == tag) return 1;
    return 0;
  endfunction

  function automatic void model_eval();
    exp_ready = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) exp_ready = 1;
    for (int f = 0; f < NF; f++) begin
      int p = -1;
      if (fu_ready[f] && !flush) begin
        for (int i = 0; i < N; i++) begin
          if (m_busy[i] && m_fu[i] == f && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_PRIO_EN
            if (p < 0 || m_seq[i] < m_seq[p]) p = i;
`else
            if (p < 0) p = i;
`endif
          end
        end
      end
      m_pick[f] = p;
    end
  endfunction

  function automatic void model_update();
    int fr = -1;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
    for (int f = 0; f < NF; f++) if (m_pick[f] >= 0) m_busy[m_pick[f]] = 0;
    for (int i = 0; i < N; i++) begin
      if (cdb_hit(m_ent[i].ps1)) m_r1[i] = 1;
      if (cdb_hit(m_ent[i].ps2)) m_r2[i] = 1;
    end
    if (dispatch_valid && fr >= 0) begin
      m_busy[fr] = 1;
      m_fu[fr]   = int'(dispatch_fu_sel);
      m_r1[fr]   = dispatch_ps1_ready || dispatch_ps1 == 0 || cdb_hit(dispatch_ps1);
      m_r2[fr]   = dispatch_ps2_ready || dispatch_ps2 == 0 || cdb_hit(dispatch_ps2);
      m_ent[fr]  = '{ps1: dispatch_ps1, ps2: dispatch_ps2, pd: dispatch_pd, rd: dispatch_rd,
                     rob_entry: dispatch_rob_entry, op: dispatch_op};
      m_seq[fr]  = seq_ctr;
      seq_ctr++;
    end
  endfunction

  // Compare DUT outputs with the model at the falling edge.
  task automatic sample_check(input string tag);
    int cnt = 0;
    @(negedge clk);
    model_eval();
    for (int i = 0; i < N; i++) cnt += int'(m_busy[i]);
    chk({tag, ".ready"}, dispatch_ready, exp_ready);
    chk({tag, ".occ"}, occupancy, cnt);
    for (int f = 0; f < NF; f++) begin
      chk($sformatf("%s.iv%0d", tag, f), issue_valid[f], m_pick[f] >= 0);
      chk($sformatf("%s.ent%0d", tag, f), issue_entry[f],
          (m_pick[f] >= 0) ? m_ent[m_pick[f]] : '0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_cycle(input string tag);
    sample_check(tag);
    advance();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    dispatch_valid = 0; cdb_valid = '0; flush = 0;
  endtask

  task automatic drive(input bit v, input int fu, input int ps1, input int ps2,
                       input bit r1, input bit r2, input int pd);
    dispatch_valid     = v;
    dispatch_fu_sel    = 1'(fu);
    dispatch_ps1       = PW'(ps1);
    dispatch_ps2       = PW'(ps2);
    dispatch_ps1_ready = r1;
    dispatch_ps2_ready = r2;
    dispatch_pd        = PW'(pd);
    dispatch_rd        = 5'(pd + 1);
    dispatch_rob_entry = 5'(pd);
    dispatch_op        = 8'(pd * 3);
  endtask

  task automatic cdb1(input int tag);
    cdb_valid = 2'b01; cdb_pd[0] = PW'(tag); cdb_pd[1] = '0;
  endtask

  // Called at posedge+1; checks reset outputs with no clock edge in between.
  task automatic do_reset(input string tag);
    rst = 0;
    #1;
    chk({tag, ".rst_ready"}, dispatch_ready, 1);
    chk({tag, ".rst_iv"}, issue_valid, 0);
    chk({tag, ".rst_occ"}, occupancy, 0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  // ---------------- table ----------------
  typedef struct {
    bit dv; int fu; int ps1; int ps2; bit r1; bit r2; int pd;
    bit [1:0] cv; int c1; bit [1:0] fr;
    bit [1:0] e_iv; int e_pd0; int e_pd1; int e_occ;
  } vec_t;

  function automatic vec_t mk(bit dv, int fu, int ps1, int ps2, bit r1, bit r2, int pd,
                              bit [1:0] cv, int c1, bit [1:0] fr,
                              bit [1:0] eiv, int ep0, int ep1, int eocc);
    vec_t v;
    v.dv = dv; v.fu = fu; v.ps1 = ps1; v.ps2 = ps2; v.r1 = r1; v.r2 = r2; v.pd = pd;
    v.cv = cv; v.c1 = c1; v.fr = fr; v.e_iv = eiv; v.e_pd0 = ep0; v.e_pd1 = ep1; v.e_occ = eocc;
    return v;
  endfunction

  vec_t tbl[15];
  localparam int FIRST_PD  = `ifdef RS_AGE_PRIO_EN 50 `else 51 `endif ;
  localparam int SECOND_PD = `ifdef RS_AGE_PRIO_EN 51 `else 50 `endif ;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 3, 4, 1, 1, 9,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b01, 9, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
    tbl[4]  = mk(1, 1, 7, 0, 0, 0, 12, 2'b10, 7, 2'b11, 2'b00, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b10, 0, 12, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 2, 1, 1, 5,  2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b01, 5, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 2, 1, 1, 33, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[12] = mk(1, 1, 3, 4, 1, 1, 34, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b11, 33, 34, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 2'b11, 2'b00, 0, 0, 0);

    @(posedge clk);
    #1;
    do_reset("init");

    // Table-driven directed vectors.
    for (int t = 0; t < 15; t++) begin
      string nm = $sformatf("tbl%0d", t);
      drive(tbl[t].dv, tbl[t].fu, tbl[t].ps1, tbl[t].ps2, tbl[t].r1, tbl[t].r2, tbl[t].pd);
      cdb_valid = tbl[t].cv; cdb_pd[0] = '0; cdb_pd[1] = PW'(tbl[t].c1);
      fu_ready = tbl[t].fr; flush = 0;
      sample_check(nm);
      chk({nm, ".iv_vec"}, issue_valid, tbl[t].e_iv);
      chk({nm, ".pd0"}, issue_entry[0].pd, tbl[t].e_pd0);
      chk({nm, ".pd1"}, issue_entry[1].pd, tbl[t].e_pd1);
      chk({nm, ".occ_tbl"}, occupancy, tbl[t].e_occ);
      $display("vec %0d: iv=%b pd0=%0d pd1=%0d occ=%0d", t, issue_valid,
               issue_entry[0].pd, issue_entry[1].pd, occupancy);
      advance();
    end
    idle();

    // Fill all entries with unready sources, overflow, then wake entry 2.
    do_reset("fill");
    fu_ready = '1;
    for (int i = 0; i < N; i++) begin
      drive(1, 0, 10 + i, 0, 0, 0, 20 + i);
      run_cycle($sformatf("fill%0d", i));
    end
    drive(1, 0, 30, 0, 1, 1, 40);
    sample_check("full");
    chk("full.ready_const", dispatch_ready, 0);
    chk("full.occ_const", occupancy, 8);
    advance();
    idle();
    cdb1(12);
    sample_check("wake2");
    chk("wake2.no_issue", issue_valid, 0);
    chk("wake2.occ_kept", occupancy, 8);
    advance();
    idle();
    sample_check("iss2");
    chk("iss2.iv", issue_valid, 2'b01);
    chk("iss2.pd", issue_entry[0].pd, 22);
    advance();
    run_cycle("after2");
    $display("fill/overflow/wake sequence done: occ=%0d", occupancy);

    // Age priority: A in entry 5, B later in entry 1, woken together.
    do_reset("age");
    fu_ready = '1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 40 + i, 0, 0, 0, 60 + i);
      run_cycle($sformatf("age_fill%0d", i));
    end
    drive(1, 0, 30, 0, 0, 0, 50);
    run_cycle("age_a");
    idle();
    cdb1(41);
    run_cycle("age_w41");
    idle();
    sample_check("age_free1");
    chk("age_free1.pd", issue_entry[1].pd, 61);
    advance();
    drive(1, 0, 30, 0, 0, 0, 51);
    run_cycle("age_b");
    idle();
    cdb1(30);
    run_cycle("age_w30");
    idle();
    sample_check("age_first");
    chk("age_first.pd", issue_entry[0].pd, FIRST_PD);
    advance();
    sample_check("age_second");
    chk("age_second.pd", issue_entry[0].pd, SECOND_PD);
    advance();
    $display("age sequence done: first=%0d second=%0d", FIRST_PD, SECOND_PD);

    // Flush with four ready entries held back by fu_ready.
    do_reset("flush");
    fu_ready = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i % 2, 1, 2, 1, 1, 8 + i);
      run_cycle($sformatf("fl_fill%0d", i));
    end
    idle();
    fu_ready = '1;
    flush = 1;
    sample_check("flush_cyc");
    chk("flush_cyc.iv", issue_valid, 0);
    chk("flush_cyc.occ", occupancy, 4);
    advance();
    idle();
    sample_check("post_flush");
    chk("post_flush.occ", occupancy, 0);
    advance();

    // Reset asserted mid-fill.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 2, 1, 1, 16 + i);
      fu_ready = '0;
      run_cycle($sformatf("mid%0d", i));
    end
    do_reset("mid_rst");
    fu_ready = '1;
    run_cycle("mid_after");
    $display("flush and mid-fill reset sequence done");

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 63));
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k] = $urandom_range(0, 1);
        cdb_pd[k]    = PW'($urandom_range(0, 15));
      end
      for (int f = 0; f < NF; f++) fu_ready[f] = $urandom_range(0, 4) != 0;
      flush = $urandom_range(0, 63) == 0;
      sample_check($sformatf("rnd%0d", c));
      $display("rnd %0d: dv=%b rdy=%b iv=%b occ=%0d fl=%b", c, dispatch_valid,
               dispatch_ready, issue_valid, occupancy, flush);
      advance();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station_param.md
RESERVATION_STATION_PARAM -- requirements
Module: reservation_station_param

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: number of RS entries (power of two, 2 to 32).
REQ-002 Parameter NUM_FU, default 2: number of issue channels, one per functional unit.
REQ-003 Parameter NUM_CDB, default 2: number of CDB wakeup ports.
REQ-004 Parameter PS_W, default 6: physical register tag width.
REQ-005 Parameter ROB_W, default 5: ROB index width.
REQ-006 Parameter OP_W, default 8: opaque opcode/control payload width.
REQ-007 Port clk, input, 1: clock; all state on rising edge.
REQ-008 Port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-009 Port flush, input, 1: squash all entries.
REQ-010 Port dispatch_valid, input, 1: dispatch request.
REQ-011 Port dispatch_ready, output, 1: at least one free entry.
REQ-012 Port dispatch_fu_sel, input, $clog2(NUM_FU): target FU channel.
REQ-013 Port dispatch_ps1 and dispatch_ps2, input, PS_W each: source tags.
REQ-014 Port dispatch_ps1_ready and dispatch_ps2_ready, input, 1 each: source ready per RAT.
REQ-015 Port dispatch_pd, input, PS_W; dispatch_rd, input, 5; dispatch_rob_entry, input, ROB_W; dispatch_op, input, OP_W: entry payload.
REQ-016 Port cdb_valid, input, NUM_CDB: per-port broadcast valid.
REQ-017 Port cdb_pd, input, NUM_CDB x PS_W: per-port broadcast tag.
REQ-018 Port fu_ready, input, NUM_FU: FU accepts an issue this cycle.
REQ-019 Port issue_valid, output, NUM_FU: per-channel issue strobe.
REQ-020 Port issue_entry, output, NUM_FU x rs_entry_t: issued entry payload (ps1, ps2, pd, rd, rob_entry, op).
REQ-021 Port occupancy, output, $clog2(NUM_ENTRIES)+1: count of busy entries.

Function
REQ-022 The block SHALL drive dispatch_ready combinationally high iff any entry is not busy; entries freed by issue in the same cycle SHALL NOT count.
REQ-023 The block SHALL write a dispatch into the lowest-index free entry at the edge where dispatch_valid and dispatch_ready are both high and flush is low; otherwise dispatch is dropped with no state change.
REQ-024 The block SHALL set an entry's ps1_v or ps2_v at the edge after any cdb_valid[k] whose cdb_pd[k] equals that tag; tag 0 SHALL always be treated as ready.
REQ-025 The block SHALL apply same-cycle bypass at dispatch: a source matching a valid CDB tag in the dispatch cycle SHALL be written ready.
REQ-026 Per channel f, the block SHALL assert issue_valid[f] combinationally iff fu_ready[f] is high, flush is low, and some busy entry with fu == f has both sources ready in registered state; the selected entry SHALL clear busy at the next edge.
REQ-027 Wakeup-to-issue latency SHALL be one cycle minimum; dispatch-to-issue SHALL be one cycle minimum.
REQ-028 The block SHALL allow all NUM_FU channels to issue in the same cycle alongside one dispatch and NUM_CDB wakeups.
REQ-029 The block SHALL update occupancy at each edge by +1 for an accepted dispatch and -1 per issued entry; it saturates at neither bound because REQ-022 prevents overflow.
REQ-030 The block SHALL clear every entry and zero occupancy at the edge where flush is high; issue_valid SHALL be 0 during the flush cycle.
REQ-031 The block SHALL drive issue_entry[f] to zero when issue_valid[f] is low.

Reset
REQ-032 Asserting rst low SHALL immediately clear all entries, age state, and occupancy; dispatch_ready SHALL then be 1 and issue_valid SHALL be 0, including when rst is asserted mid-operation.

Configuration
REQ-033 With RS_AGE_PRIO_EN defined, each channel SHALL select the oldest ready entry using an NUM_ENTRIES x NUM_ENTRIES age matrix updated on dispatch. Without it, the lowest-index ready entry SHALL win and no age state SHALL exist.

Structure
REQ-034 rs_entry_t, NUM_ENTRIES/NUM_FU/NUM_CDB defaults, and tag widths SHALL live in rv32i_types.
REQ-035 Per-channel selection SHALL be a sub-module rs_issue_select, instantiated NUM_FU times.

Verification
REQ-036 Reset followed by a dispatch of fu 0, ps1=3/ps2=4 ready -> issue_valid[0]=1 the next cycle with pd echoed, and occupancy goes 1 then 0.
REQ-037 Fill all 8 entries with unready sources -> dispatch_ready=0 and a 9th dispatch is dropped; CDB tag of entry 2 -> that entry issues the following cycle.
REQ-038 Dispatch ps1=7 unready while cdb_valid[1]=1, cdb_pd[1]=7 in the same cycle -> entry issues the next cycle.
REQ-039 With RS_AGE_PRIO_EN, dispatch A to entry 5 and later B to entry 1, then wake both together -> A issues first; without the macro, B issues first.
REQ-040 Flush with 4 busy entries and fu_ready all 1 -> no issue in that cycle and occupancy=0 after; rst pulsed low mid-fill -> all outputs return to reset values without a clock edge.
